map_sst_seq: RTL and testbench

//  Save-state sequencer for one mapper's register file. On a save command it walks the

---
 rtl/map_sst_if.sv | 39 +++
 rtl/map_sst_seq.sv | 137 +++++++++++++
 tb/tb_map_sst_seq.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/map_sst_if.sv
// State-channel bundle between the save-state sequencer and its environment:
// the mapper's sst register bus plus the outgoing save stream and the
// incoming load stream.
interface map_sst_if;
  // mapper sst bus
  logic       sst_act;
  logic [7:0] sst_addr;
  logic       sst_we_reg;
  logic [7:0] sst_dato;
  logic [7:0] sst_di;
  // save stream (sequencer -> host)
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  // load stream (host -> sequencer)
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  // sequencer side
  modport master (
    output sst_act, sst_addr, sst_we_reg, sst_dato,
    input  sst_di,
    output out_data, out_valid,
    input  out_ready,
    input  in_data, in_valid,
    output in_ready
  );

  // mapper / host side
  modport slave (
    input  sst_act, sst_addr, sst_we_reg, sst_dato,
    output sst_di,
    input  out_data, out_valid,
    output out_ready,
    output in_data, in_valid,
    input  in_ready
  );
endinterface

// File: rtl/map_sst_seq.sv
// Save-state sequencer for one mapper's register file.
// Save: emits the mapper index (read from ID_ADDR) followed by regs 0..REG_COUNT-1.
// Load: checks the header byte against map_idx, then writes regs 0..REG_COUNT-1.
module map_sst_seq #(
  parameter int REG_COUNT = 10,
  parameter int ID_ADDR   = 127
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_save_i,
  input  logic       cmd_load_i,
  input  logic [7:0] map_idx_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  map_sst_if.master  bus
);

  localparam logic [6:0] LAST_IDX = 7'(REG_COUNT - 1);
  localparam logic [7:0] ID_A     = 8'(ID_ADDR);

  typedef enum logic [2:0] {
    IDLE, S_RD, S_OUT, L_HDR, L_DAT, L_WR, FIN, FAIL
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] idx_q,   idx_d;     // register index within the window
  logic [7:0] addr_q,  addr_d;    // sst_addr
  logic [7:0] dato_q,  dato_d;    // load byte held for the write strobe
  logic [7:0] odata_q, odata_d;   // save byte held for the stream handshake
  logic       hdr_q,   hdr_d;     // current save byte is the header

  // State and datapath registers; reset aborts any operation immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      dato_q  <= '0;
      odata_q <= '0;
      hdr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      dato_q  <= dato_d;
      odata_q <= odata_d;
      hdr_q   <= hdr_d;
    end
  end

  // Next-state logic; every register holds unless a transition updates it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    dato_d  = dato_q;
    odata_d = odata_q;
    hdr_d   = hdr_q;
    case (state_q)
      IDLE: begin
        // save has priority; a simultaneous load pulse is dropped
        if (cmd_save_i) begin
          state_d = S_RD;
          addr_d  = ID_A;
          hdr_d   = 1'b1;
          idx_d   = '0;
        end else if (cmd_load_i) begin
          state_d = L_HDR;
          idx_d   = '0;
        end
      end
      S_RD: begin
        // address has been stable a full cycle; capture the mapper read
        odata_d = bus.sst_di;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          if (hdr_q) begin
            hdr_d   = 1'b0;
            idx_d   = '0;
            addr_d  = '0;
            state_d = S_RD;
          end else if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + 7'd1;
            addr_d  = {1'b0, idx_q + 7'd1};
            state_d = S_RD;
          end else begin
            state_d = FIN;
          end
        end
      end
      L_HDR: begin
        if (bus.in_valid) begin
          if (bus.in_data == map_idx_i) begin
            idx_d   = '0;
            state_d = L_DAT;
          end else begin
            state_d = FAIL;
          end
        end
      end
      L_DAT: begin
        if (bus.in_valid) begin
          dato_d  = bus.in_data;
          addr_d  = {1'b0, idx_q};
          state_d = L_WR;
        end
      end
      L_WR: begin
        if (idx_q == LAST_IDX) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q + 7'd1;
          state_d = L_DAT;
        end
      end
      FIN:     state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are pure state decodes so they cannot glitch with the inputs.
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == FIN);
  assign err_o          = (state_q == FAIL);
  assign bus.sst_act    = (state_q != IDLE);
  assign bus.sst_addr   = addr_q;
  assign bus.sst_we_reg = (state_q == L_WR);
  assign bus.sst_dato   = dato_q;
  assign bus.out_data   = odata_q;
  assign bus.out_valid  = (state_q == S_OUT);
  assign bus.in_ready   = (state_q == L_HDR) || (state_q == L_DAT);

endmodule

// File: tb/tb_map_sst_seq.sv
// Bench for map_sst_seq: mapper register model, save-stream sink with
// optional backpressure, load-stream source, and queue-based scoreboards.
module tb_map_sst_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_save = 1'b0;
  logic       cmd_load = 1'b0;
  logic [7:0] map_idx  = 8'h52;
  logic       busy, done, err;

  map_sst_if bus();

  map_sst_seq #(.REG_COUNT(10), .ID_ADDR(127)) dut (
    .clk(clk), .rst(rst), .cmd_save_i(cmd_save), .cmd_load_i(cmd_load),
    .map_idx_i(map_idx), .busy_o(busy), .done_o(done), .err_o(err), .bus(bus)
  );

  always #5 clk = ~clk;

  // mapper register model; reset preloads 0x10+i, header reads 0x52
  logic [7:0] regs [0:127];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) regs[i] <= 8'(8'h10 + i);
    end else if (bus.sst_we_reg) begin
      regs[bus.sst_addr[6:0]] <= bus.sst_dato;
    end
  end
  assign bus.sst_di = (bus.sst_addr == 8'd127) ? 8'h52 : regs[bus.sst_addr[6:0]];

  int nvec = 0, nfail = 0;
  logic [7:0]  exp_out [$];
  logic [15:0] exp_wr  [$];
  int done_cnt = 0, err_cnt = 0, we_cnt = 0, inr_cnt = 0;
  logic       stalled = 1'b0;
  logic [7:0] held = '0;
  int rdy_mode = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: pops scoreboards on each output event, checks stall stability
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (bus.in_ready) inr_cnt++;
    if (bus.out_valid && bus.in_ready) chk("out_valid_and_in_ready", 1, 0);
    if (bus.sst_we_reg) begin
      we_cnt++;
      if (exp_wr.size() == 0) chk("unexpected_write", {16'h0, bus.sst_addr, bus.sst_dato}, 32'hFFFF_FFFF);
      else chk("write_addr_data", {16'h0, bus.sst_addr, bus.sst_dato}, {16'h0, exp_wr.pop_front()});
    end
    if (bus.out_valid) begin
      if (stalled) chk("stall_hold_data", bus.out_data, held);
      if (bus.out_ready) begin
        if (exp_out.size() == 0) chk("unexpected_out_byte", bus.out_data, 32'hFFFF_FFFF);
        else chk("out_byte", bus.out_data, exp_out.pop_front());
      end
      stalled = !bus.out_ready;
      held    = bus.out_data;
    end else begin
      if (stalled) chk("stall_valid_dropped", 0, 1);
      stalled = 1'b0;
    end
  end

  // sink: always ready, or 3 cycles low / 3 cycles high
  initial begin
    int rc;
    rc = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rc++;
      bus.out_ready = (rdy_mode == 0) ? 1'b1 : (((rc / 3) % 2) == 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic s, input logic l);
    cmd_save = s; cmd_load = l;
    tick();
    cmd_save = 1'b0; cmd_load = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("in_ready_timeout", 0, 1);
  endtask

  task automatic wait_end(input int exp_done, input int exp_err);
    int d0, e0;
    logic ended;
    d0 = done_cnt; e0 = err_cnt; ended = 1'b0;
    for (int i = 0; i < 400 && !ended; i++) begin
      @(negedge clk);
      if (!busy) ended = 1'b1;
    end
    if (!ended) chk("busy_timeout", 0, 1);
    chk("done_pulses", done_cnt - d0, exp_done);
    chk("err_pulses", err_cnt - e0, exp_err);
    tick();
  endtask

  task automatic do_save(input logic [7:0] base);
    exp_out.push_back(8'h52);
    for (int i = 0; i < 10; i++) exp_out.push_back(8'(base + i));
    pulse(1'b1, 1'b0);
    wait_end(1, 0);
    chk("save_queue_drained", exp_out.size(), 0);
  endtask

  task automatic do_load(input logic [7:0] base);
    for (int i = 0; i < 10; i++) exp_wr.push_back({8'(i), 8'(base + i)});
    pulse(1'b0, 1'b1);
    send(8'h52);
    for (int i = 0; i < 10; i++) begin
      tick();
      send(8'(base + i));
    end
    wait_end(1, 0);
    chk("load_queue_drained", exp_wr.size(), 0);
  endtask

  initial begin
    int w0, i0, d0, e0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    // reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_act", bus.sst_act, 0);
    chk("rst_addr", bus.sst_addr, 0);
    chk("rst_we", bus.sst_we_reg, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    tick();
    rst = 1'b0;
    tick();

    // 1: save, sink always ready
    rdy_mode = 0;
    do_save(8'h10);

    // 2: save with backpressure
    rdy_mode = 1;
    do_save(8'h10);
    rdy_mode = 0;

    // 3: load A0..A9, then read back
    do_load(8'hA0);
    do_save(8'hA0);

    // 4: bad header -> err, no writes, regs untouched
    w0 = we_cnt;
    pulse(1'b0, 1'b1);
    send(8'h51);
    @(negedge clk);
    chk("hdr_bad_err", err, 1);
    chk("hdr_bad_busy_1", busy, 1);
    @(negedge clk);
    chk("hdr_bad_busy_2", busy, 0);
    chk("hdr_bad_no_writes", we_cnt - w0, 0);
    tick();
    do_save(8'hA0);

    // 5: simultaneous commands -> save; load during save ignored
    exp_out.push_back(8'h52);
    for (int i = 0; i < 10; i++) exp_out.push_back(8'(8'hA0 + i));
    i0 = inr_cnt;
    pulse(1'b1, 1'b1);
    tick(); tick();
    pulse(1'b0, 1'b1);
    wait_end(1, 0);
    chk("both_cmd_queue_drained", exp_out.size(), 0);
    tick(); tick();
    chk("both_cmd_no_load", inr_cnt - i0, 0);
    chk("both_cmd_idle", busy, 0);

    // 6: reset mid-load, then a clean load
    for (int i = 0; i < 4; i++) exp_wr.push_back({8'(i), 8'(8'hC0 + i)});
    d0 = done_cnt; e0 = err_cnt;
    pulse(1'b0, 1'b1);
    send(8'h52);
    for (int i = 0; i < 4; i++) begin
      tick();
      send(8'(8'hC0 + i));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_act", bus.sst_act, 0);
    chk("rst_mid_writes", exp_wr.size(), 0);
    tick(); tick();
    chk("rst_mid_no_done", done_cnt - d0, 0);
    chk("rst_mid_no_err", err_cnt - e0, 0);
    do_load(8'hB0);
    do_save(8'hB0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
